// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the memory-to-LCD display reader.
//   disp_state_t     - reader FSM states
//   ASCII_*          - character codes used by the hex renderer and reset rows
//   WORDS_PER_FRAME  - words fetched per refresh (two per LCD row)
//   nibble_to_ascii  - one hex nibble to its uppercase ASCII character
package display_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitGrant,
    StAddr,
    StCapt,
    StCommit
  } disp_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam int unsigned WORDS_PER_FRAME = 4;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = ASCII_ZERO + {4'h0, nib};
    end else begin
      ch = ASCII_A + {4'h0, nib - 4'd10};
    end
    return ch;
  endfunction

endpackage

// File: rtl/hex_to_ascii8.sv
// hex_to_ascii8: renders a 32-bit word as 8 uppercase hex ASCII characters.
// Purely combinational.
//   i_word  [31:0] word to render
//   o_ascii [63:0] characters; [63:56] is the most significant nibble (leftmost)
module hex_to_ascii8
  import display_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [63:0] o_ascii
);

  // Nibble i lands in byte i, so the top nibble becomes the leftmost character.
  always_comb begin
    o_ascii = '0;
    for (int i = 0; i < 8; i++) begin
      o_ascii[i*8 +: 8] = nibble_to_ascii(i_word[i*4 +: 4]);
    end
  end

endmodule

// File: rtl/mem_display_reader.sv
// mem_display_reader: fetches a 4-word window of data memory and shows it as hex
// on the two 16-character LCD rows. Refreshes periodically or on a start pulse,
// sharing the memory port through a request/grant handshake.
//   clk, nrst        clock, asynchronous active-low reset
//   enable           lets the periodic refresh counter run
//   start            one-cycle pulse requesting an immediate refresh
//   mem_req          request for the data-memory port
//   mem_grant        port ownership; may drop at any time
//   mem_addr [31:0]  byte address (0 outside the address/capture states)
//   mem_rdata[31:0]  memory read data
//   row1/row2[127:0] LCD lines, [127:120] is the leftmost character
//   busy             high whenever the FSM is not idle
//   done             one-cycle pulse in the first cycle new rows are visible
module mem_display_reader
  import display_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0400,
  parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         enable,
  input  logic         start,
  output logic         mem_req,
  input  logic         mem_grant,
  output logic [31:0]  mem_addr,
  input  logic [31:0]  mem_rdata,
  output logic [127:0] row1,
  output logic [127:0] row2,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CntW = $clog2(REFRESH_CYCLES);
  localparam int unsigned IdxW = $clog2(WORDS_PER_FRAME);
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WORDS_PER_FRAME - 1);

  disp_state_t    r_state;
  disp_state_t    w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [IdxW-1:0] r_idx;
  logic [31:0]    r_shadow [WORDS_PER_FRAME];
  logic [127:0]   r_row1;
  logic [127:0]   r_row2;
  logic           r_done;
  logic           w_trigger;
  logic [63:0]    w_ascii [WORDS_PER_FRAME];

  // start and counter expiry in the same cycle collapse into a single trigger.
  assign w_trigger = (r_state == StIdle) &&
                     (start || (enable && (r_cnt == CntLast)));

  for (genvar g = 0; g < WORDS_PER_FRAME; g++) begin : g_render
    hex_to_ascii8 u_hex (
      .i_word  (r_shadow[g]),
      .o_ascii (w_ascii[g])
    );
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_trigger) w_state_next = StWaitGrant;
      end
      StWaitGrant: begin
        if (mem_grant) w_state_next = StAddr;
      end
      StAddr: begin
        w_state_next = mem_grant ? StCapt : StWaitGrant;
      end
      StCapt: begin
        if (!mem_grant) begin
          w_state_next = StWaitGrant;
        end else if (r_idx == IdxLast) begin
          w_state_next = StCommit;
        end else begin
          w_state_next = StAddr;
        end
      end
      StCommit: begin
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    busy     = (r_state != StIdle);
    unique case (r_state)
      StWaitGrant: mem_req = 1'b1;
      StAddr, StCapt: begin
        mem_req  = 1'b1;
        mem_addr = BASE_ADDR + 32'({r_idx, 2'b00});
      end
      default: ;
    endcase
  end

  // Refresh counter: only advances in IDLE, cleared on every trigger.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (r_state == StIdle) begin
      if (w_trigger) begin
        r_cnt <= '0;
      end else if (enable) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Word index and shadow capture. A grant loss rewinds to word 0; the shadow
  // words already captured are simply overwritten by the restarted frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_idx <= '0;
      for (int i = 0; i < WORDS_PER_FRAME; i++) r_shadow[i] <= '0;
    end else begin
      unique case (r_state)
        StWaitGrant: r_idx <= '0;
        StAddr: begin
          if (!mem_grant) r_idx <= '0;
        end
        StCapt: begin
          if (!mem_grant) begin
            r_idx <= '0;
          end else begin
            r_shadow[r_idx] <= mem_rdata;
            if (r_idx != IdxLast) r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Both rows load on the same edge so the LCD never shows a mixed frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_row1 <= {16{ASCII_SPACE}};
      r_row2 <= {16{ASCII_SPACE}};
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == StCommit);
      if (r_state == StCommit) begin
        r_row1 <= {w_ascii[0], w_ascii[1]};
        r_row2 <= {w_ascii[2], w_ascii[3]};
      end
    end
  end

  assign row1 = r_row1;
  assign row2 = r_row2;
  assign done = r_done;

endmodule

// File: doc/mem_display_reader.md
# mem_display_reader

Reads a fixed window of data memory and renders it as hexadecimal ASCII on the two 16-character LCD rows. It is the read-side counterpart of the keypad/FPGA write path: that path writes operands into RAM, and this block fetches four words and drives `row1` and `row2` into the LCD controller. It shares the data-memory port through the FPGA/CPU address/data muxes using a request/grant pair. Refreshes are periodic or on demand.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0400, byte address of word 0 of the display window; must be 4-byte aligned.
- `REFRESH_CYCLES`, 1_000_000, number of clock cycles between automatic refreshes; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `nrst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  when high, the periodic refresh counter runs.
- `start`  in  1  single-cycle pulse that requests an immediate refresh.
- `mem_req`  out  1  request to own the data-memory port.
- `mem_grant`  in  1  the port is owned by this block; may drop at any time.
- `mem_addr`  out  32  byte address presented to data memory.
- `mem_rdata`  in  32  data-memory read data.
- `row1`  out  128  LCD line 1; bits [127:120] hold the leftmost character.
- `row2`  out  128  LCD line 2; same character ordering.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse, high in the first cycle the new rows are visible.

## Operation
- Frame layout:
  - word0 and word1 form `row1` (word0 fills the left 8 characters).
  - word2 and word3 form `row2`.
  - Word k is read from `BASE_ADDR + 4*k`.
- Hex rendering:
  - Each word becomes 8 characters, most significant nibble first.
  - Nibbles 0–9 map to 8'h30+n; nibbles A–F map to 8'h41+(n−10), uppercase.
- State machine: IDLE, WAIT_GRANT, ADDR, CAPT, COMMIT.
  - IDLE: `mem_req`=0. The refresh counter increments while `enable`=1 and holds while `enable`=0. A refresh is triggered by `start`=1, or by the counter equal to REFRESH_CYCLES−1 with `enable`=1. On a trigger, go to WAIT_GRANT and clear the counter. A `start` pulse and a counter expiry in the same cycle produce one refresh. `start` works even when `enable`=0.
  - WAIT_GRANT: `mem_req`=1 and `idx`=0. Go to ADDR when `mem_grant`=1.
  - ADDR: `mem_req`=1 and `mem_addr`=BASE_ADDR+4*idx. Go to CAPT.
  - CAPT: `mem_req`=1 and `mem_addr` is held. Load `shadow[idx]` from `mem_rdata`. If `idx`=3, go to COMMIT; otherwise increment `idx` and go to ADDR.
  - COMMIT: `mem_req`=0. Load `row1` and `row2` from the rendered shadow words in one edge, so both rows update atomically. Go to IDLE.
- Grant loss: if `mem_grant`=0 in ADDR or CAPT, go to WAIT_GRANT.
  - `idx` resets to 0 and the partial shadow data is discarded.
  - `row1` and `row2` are unchanged; they never show a mixed frame.
- `start` while `busy`=1 is ignored (not queued).
- `mem_addr` is 0 whenever the state is not ADDR or CAPT.

## Timing
- Reset values:
  - `row1` and `row2` are 16 ASCII spaces (each byte 8'h20).
  - `mem_req`, `mem_addr`, `busy` and `done` are all 0.
  - State is IDLE and the counter, `idx` and shadow registers are 0.
- Reset asserted mid-frame aborts immediately to the reset values above.
- `mem_rdata` is sampled at the end of CAPT. Memory must return valid data within one cycle of `mem_addr` being presented in ADDR.
- Latency with grant held high, counting the cycle `start` is sampled as cycle 0:
  - Cycle 1: WAIT_GRANT.
  - Cycles 2–9: ADDR/CAPT pairs for the four words.
  - Cycle 10: COMMIT.
  - Cycle 11: new rows visible, `done`=1, `busy`=0.
- `busy` is 1 in cycles 1–10.
- Automatic refresh: IDLE is entered at cycle T. With `enable` held high, the trigger is taken at cycle T+REFRESH_CYCLES−1.

## Structure
- Shared package `display_pkg` holds:
  - the state enum `disp_state_t`;
  - constants `ASCII_ZERO` = 8'h30, `ASCII_A` = 8'h41 and `ASCII_SPACE` = 8'h20;
  - `WORDS_PER_FRAME` = 4.
- Sub-module `hex_to_ascii8`: purely combinational, 32-bit word in, 64-bit ASCII out. Instantiate it four times, one per shadow word.
- The FSM, refresh counter, `idx` and shadow registers live in `mem_display_reader`.

## Test plan
- Reset, then check the outputs → `row1` and `row2` are all 8'h20 and `mem_req`=`busy`=`done`=0.
- Memory model holds words 0x0123_4567, 0x89AB_CDEF, 0xDEAD_BEEF and 0x0000_000F, with grant tied high. Pulse `start` → `mem_addr` takes 0x400, 0x404, 0x408 and 0x40C, and `done` pulses at cycle 11. `row1` reads "0123456789ABCDEF" and `row2` reads "DEADBEEF0000000F".
- Pulse `start` with grant held low for 5 cycles → `mem_req` stays high and `mem_addr`=0, then the frame completes 10 cycles after grant rises.
- Drop `mem_grant` for 1 cycle during the CAPT of word 2 → the read restarts at 0x400. `row1` and `row2` keep their old values until the full frame commits.
- Use REFRESH_CYCLES=8 and `enable`=1 → frames start every 8 cycles after each return to IDLE. With `enable`=0, the counter freezes and no refresh occurs, but `start` still works.
- Deassert `nrst` during ADDR of word 1 → all outputs return to reset values asynchronously, and a frame started after reset completes normally.
